// File: rtl/dac_window_pkg.sv
// ----------------------------------------------------------------------------
// dac_window_pkg
//   Shared definitions for the DAC time-window spike discriminator:
//   FSM state encoding, default sizes and the field layout of the exported
//   fsm_window_state word.
// ----------------------------------------------------------------------------
package dac_window_pkg;

    localparam int NCH_DEFAULT   = 8;
    localparam int CNT_W_DEFAULT = 16;

    // fsm_window_state = {count[15:0], hit[7:0], 6'b0, state[1:0]}
    localparam int COUNT_LSB = 16;
    localparam int HIT_LSB   = 8;
    localparam int STATE_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_EVAL  = 2'd2
    } win_state_t;

endpackage

// File: rtl/dac_window_channel.sv
// ----------------------------------------------------------------------------
// dac_window_channel
//   One channel of the window discriminator. Records whether a threshold
//   crossing fell inside this channel's [win_start, win_stop] window during
//   the current sequence, and reports whether that outcome satisfies the
//   channel's inclusion/exclusion rule.
// Ports
//   dataclk    in   system clock
//   reset      in   synchronous, active-high
//   clear      in   block disabled: drop the hit bit
//   restart    in   trigger tick: the hit bit restarts from this tick's result
//   check_en   in   this tick is part of the sequence and is window-checked
//   count      in   sample index of the current tick
//   win_start  in   window start (inclusive)
//   win_stop   in   window stop (inclusive); start > stop never hits
//   thresh     in   threshold crossing for the current sample
//   edge_type  in   0 = crossing required, 1 = crossing forbidden
//   enable     in   channel participates in the decision
//   hit        out  sticky in-window crossing flag
//   ok         out  channel satisfies its rule (always 1 when disabled)
// ----------------------------------------------------------------------------
module dac_window_channel
    import dac_window_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             dataclk,
    input  logic             reset,
    input  logic             clear,
    input  logic             restart,
    input  logic             check_en,
    input  logic [CNT_W-1:0] count,
    input  logic [CNT_W-1:0] win_start,
    input  logic [CNT_W-1:0] win_stop,
    input  logic             thresh,
    input  logic             edge_type,
    input  logic             enable,
    output logic             hit,
    output logic             ok
);

    logic in_window;
    logic hit_now;

    // Both bounds inclusive and unsigned; an inverted window is empty by construction.
    assign in_window = (count >= win_start) && (count <= win_stop);
    assign hit_now   = thresh && in_window;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge dataclk) begin
        if (reset || clear) begin
            hit <= 1'b0;
        end else if (check_en) begin
            hit <= (restart ? 1'b0 : hit) | hit_now;
        end
    end

    assign ok = !enable || (edge_type ? !hit : hit);

endmodule

// File: rtl/dac_window_discriminator.sv
// ----------------------------------------------------------------------------
// dac_window_discriminator
//   Time-window spike discriminator for the DAC channels. A rising crossing
//   on channel 0 starts a sample-counted sequence; every channel checks for
//   crossings inside its own window, and at the configured maximum count a
//   pass/fail decision is issued.
// Ports
//   dataclk           in   system clock, single domain
//   reset             in   synchronous, active-high
//   sample_tick       in   one-cycle pulse per sample frame
//   thresh_in         in   per-channel crossing, valid on sample_tick
//   DAC_en            in   channel participates in the decision
//   DAC_fsm_mode      in   block enable; 0 forces IDLE and clears results
//   DAC_start_win     in   packed window starts, ch k at [CNT_W*k +: CNT_W]
//   DAC_stop_win      in   packed window stops, same packing
//   DAC_stop_max      in   sample count at which the decision is made
//   DAC_edge_type     in   0 = inclusion, 1 = exclusion
//   window_pass       out  one-cycle pulse on a passing decision
//   window_match      out  result of the last decision, held
//   busy              out  high in COUNT or EVAL
//   fsm_window_state  out  {count, hit, 6'b0, state}
// ----------------------------------------------------------------------------
module dac_window_discriminator
    import dac_window_pkg::*;
#(
    parameter int NCH   = NCH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                 dataclk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic [NCH-1:0]       thresh_in,
    input  logic [NCH-1:0]       DAC_en,
    input  logic                 DAC_fsm_mode,
    input  logic [NCH*CNT_W-1:0] DAC_start_win,
    input  logic [NCH*CNT_W-1:0] DAC_stop_win,
    input  logic [CNT_W-1:0]     DAC_stop_max,
    input  logic [NCH-1:0]       DAC_edge_type,
    output logic                 window_pass,
    output logic                 window_match,
    output logic                 busy,
    output logic [31:0]          fsm_window_state
);

    win_state_t           state, state_next;
    logic [CNT_W-1:0]     count, count_next, count_inc;
    logic                 prev0;

    logic [NCH*CNT_W-1:0] snap_start, snap_stop;
    logic [CNT_W-1:0]     snap_stop_max;
    logic [NCH-1:0]       snap_edge, snap_en;

    logic                 trigger;
    logic                 check_en;
    logic [CNT_W-1:0]     chk_count;
    logic [NCH-1:0]       hit, ok;
    logic                 pass_all;

    // A tick in EVAL is handled like an IDLE tick, so only COUNT blocks a
    // retrigger. prev0 makes channel 0 edge-sensitive across ticks.
    assign trigger   = sample_tick && DAC_fsm_mode && thresh_in[0] && !prev0
                       && (state != ST_COUNT);
    assign check_en  = sample_tick && DAC_fsm_mode && (trigger || state == ST_COUNT);

    // count holds the index of the last processed tick; the trigger tick is
    // index 0 and each COUNT tick is the next index. Since count < stop_max
    // while in COUNT, the increment can never wrap.
    assign count_inc = count + CNT_W'(1);
    assign chk_count = trigger ? '0 : count_inc;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge dataclk) begin
        if (reset) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        count_next = count;
        if (!DAC_fsm_mode) begin
            state_next = ST_IDLE;
            count_next = '0;
        end else begin
            case (state)
                ST_COUNT: begin
                    if (sample_tick) begin
                        count_next = count_inc;
                        if (count_inc == snap_stop_max) begin
                            state_next = ST_EVAL;
                        end
                    end
                end
                default: begin
                    // IDLE, and EVAL which lasts a single cycle.
                    state_next = ST_IDLE;
                    if (trigger) begin
                        count_next = '0;
                        // The snapshot is not loaded yet on the trigger tick.
                        state_next = (DAC_stop_max == '0) ? ST_EVAL : ST_COUNT;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------- datapath registers
    always_ff @(posedge dataclk) begin
        if (reset) begin
            prev0         <= 1'b0;
            snap_start    <= '0;
            snap_stop     <= '0;
            snap_stop_max <= '0;
            snap_edge     <= '0;
            snap_en       <= '0;
            window_match  <= 1'b0;
        end else begin
            if (sample_tick) begin
                prev0 <= thresh_in[0];
            end
            if (trigger) begin
                snap_start    <= DAC_start_win;
                snap_stop     <= DAC_stop_win;
                snap_stop_max <= DAC_stop_max;
                snap_edge     <= DAC_edge_type;
                snap_en       <= DAC_en;
            end
            if (!DAC_fsm_mode) begin
                window_match <= 1'b0;
            end else if (state == ST_EVAL) begin
                window_match <= pass_all;
            end
        end
    end

    // ---------------------------------------------------------- channels
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        dac_window_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .dataclk   (dataclk),
            .reset     (reset),
            .clear     (!DAC_fsm_mode),
            .restart   (trigger),
            .check_en  (check_en),
            .count     (chk_count),
            // Live bounds on the trigger tick, snapshot for the rest.
            .win_start (trigger ? DAC_start_win[k*CNT_W +: CNT_W]
                                : snap_start[k*CNT_W +: CNT_W]),
            .win_stop  (trigger ? DAC_stop_win[k*CNT_W +: CNT_W]
                                : snap_stop[k*CNT_W +: CNT_W]),
            .thresh    (thresh_in[k]),
            .edge_type (snap_edge[k]),
            .enable    (snap_en[k]),
            .hit       (hit[k]),
            .ok        (ok[k])
        );
    end

    // Disabled channels report ok = 1, so no enabled channel means pass.
    assign pass_all    = &ok;

    // ----------------------------------------------------------- outputs
    assign window_pass = (state == ST_EVAL) && DAC_fsm_mode && pass_all;
    assign busy        = (state == ST_COUNT) || (state == ST_EVAL);

    always_comb begin
        fsm_window_state                     = '0;
        fsm_window_state[COUNT_LSB +: CNT_W] = count;
        fsm_window_state[HIT_LSB +: NCH]     = hit;
        fsm_window_state[STATE_LSB +: 2]     = state;
    end

endmodule
